spi_slave_param: RTL and testbench
==================================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8, SPI word width in bits, legal range 8-32.
REQ-002 Parameter PSEL_W, default 5, peripheral-select width; SHALL satisfy PSEL_W <= DATA_W-1.
REQ-003 Parameter CPOL, default 0, SPI clock idle level.
REQ-004 Parameter CPHA, default 0, SPI clock phase.
REQ-005 Parameter SYNC_STAGES, default 2, synchroniser depth on SPI inputs, legal range 2-3.
REQ-006 clk_clk  in  1  single system clock; all logic is synchronous to its rising edge.
REQ-007 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-008 ispi_sclk  in  1  SPI serial clock, asynchronous to clk_clk.
REQ-009 ispi_ss_n  in  1  SPI slave select, active low, asynchronous.
REQ-010 ispi_in  in  1  MOSI, asynchronous.
REQ-011 ispi_send_word  in  DATA_W  read data supplied by the peripheral.
REQ-012 ospi_out  out  1  MISO.
REQ-013 ospi_rcv_cmd  out  DATA_W  last received command word.
REQ-014 ospi_rcv_word  out  DATA_W  last received data word.
REQ-015 ospi_periph_slct  out  PSEL_W  peripheral select, equal to rcv_cmd[PSEL_W-1:0].
REQ-016 ospi_write_sig  out  1  one-cycle write strobe.
REQ-017 ospi_inc_wraddr  out  1  one-cycle address-increment strobe.
REQ-018 ospi_rd_req  out  1  one-cycle request for the next send word.
REQ-019 ospi_frame_active  out  1  high while a frame is in progress.

Function
REQ-020 ispi_sclk, ispi_ss_n and ispi_in SHALL each pass through a SYNC_STAGES flip-flop synchroniser; edge detection SHALL use the synchronised sclk only.
REQ-021 The sample edge SHALL be the rising sclk edge when CPOL==CPHA, else the falling edge; the shift edge SHALL be the opposite edge.
REQ-022 Bits SHALL be shifted MSB first, on both MOSI and MISO.
REQ-023 FSM states: IDLE, CMD, DATA. IDLE->CMD on synchronised ss_n falling; CMD->DATA after DATA_W sampled bits; CMD/DATA->IDLE on synchronised ss_n rising.
REQ-024 On command completion: rcv_cmd and periph_slct SHALL update in the same cycle; the command is a write when rcv_cmd[DATA_W-1]=1, else a read.
REQ-025 Write frame: on each completed data word, rcv_word SHALL update and write_sig SHALL pulse in the same cycle; inc_wraddr SHALL pulse exactly one cycle after write_sig.
REQ-026 Read frame: rd_req SHALL pulse on command completion and on each completed data word; ispi_send_word SHALL be captured into the TX shift register exactly 2 clk cycles after each rd_req pulse.
REQ-027 Read frame: inc_wraddr SHALL pulse in the cycle after each rd_req; write_sig SHALL stay low.
REQ-028 Bursts SHALL be unlimited in length; the internal bit counter SHALL wrap at DATA_W, with no word-count limit.
REQ-029 ss_n rising mid-word: the partial word SHALL be discarded with no strobe; the bit counter SHALL clear.
REQ-030 A frame terminated before command completion SHALL leave rcv_cmd and periph_slct unchanged.
REQ-031 ospi_out SHALL be 0 when not in a read DATA state; during a read DATA word it SHALL present the TX register MSB, updated on the shift edge (CPHA=0: first bit valid before the first sample edge).
REQ-032 frame_active SHALL equal (state != IDLE).
REQ-033 Correct operation SHALL be guaranteed for f_clk >= 8 * f_sclk.

Reset
REQ-034 While reset_reset_n is low, all outputs, registers and synchronisers SHALL be 0, and the FSM SHALL be in IDLE.
REQ-035 A frame in progress at reset assertion SHALL be abandoned.
REQ-036 After reset release, the block SHALL not start a frame until it sees a synchronised ss_n falling edge (ss_n held low through reset SHALL be ignored until it rises and falls again).

Verification
REQ-037 Mode 0, DATA_W=8, write frame with cmd 0x85 then data 0x3C, 0xA5 -> periph_slct=0x05; write_sig pulses twice with rcv_word 0x3C then 0xA5; inc_wraddr pulses one cycle after each.
REQ-038 Read frame with cmd 0x03 and send_word 0x5A then 0xC3 -> MISO returns 0x5A then 0xC3; rd_req pulses 3 times; write_sig never pulses.
REQ-039 ss_n deasserted after 5 bits of a data word -> no write_sig; frame_active falls; next frame decodes correctly.
REQ-040 For each of the 4 CPOL/CPHA builds with DATA_W=16, write cmd 0x8001 then data 0xBEEF -> rcv_word=0xBEEF.
REQ-041 Reset asserted mid-command -> all outputs 0 immediately (asynchronous); a new frame after release decodes correctly.
REQ-042 Burst of 300 write words -> 300 write_sig and 300 inc_wraddr pulses, with no lost or extra strobes.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave with a command word followed by an unlimited burst of data words.
// Drives write/read strobes for a simple register peripheral.
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int PSEL_W      = 5,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              ispi_sclk,
    input  logic              ispi_ss_n,
    input  logic              ispi_in,
    input  logic [DATA_W-1:0] ispi_send_word,
    output logic              ospi_out,
    output logic [DATA_W-1:0] ospi_rcv_cmd,
    output logic [DATA_W-1:0] ospi_rcv_word,
    output logic [PSEL_W-1:0] ospi_periph_slct,
    output logic              ospi_write_sig,
    output logic              ospi_inc_wraddr,
    output logic              ospi_rd_req,
    output logic              ospi_frame_active
);

    localparam int              CNT_W          = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(DATA_W - 1);
    localparam bit              SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Input synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic sample_edge;
    logic shift_edge;
    logic ss_fall;
    logic ss_rise;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   cmd_q, cmd_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                is_wr_q, is_wr_d;
    logic                write_sig_q, write_sig_d;
    logic                rd_req_q, rd_req_d;
    logic                inc_q, inc_d;
    logic                rd_dly_q, rd_dly_d;
    logic [DATA_W-1:0]   rx_next;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ispi_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ispi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], ispi_in};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Synchronisers reset to 0, so ss_n held low through reset never looks like a falling edge.
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign ss_fall     = ~ss_s & ss_prev_q;
    assign ss_rise     = ss_s & ~ss_prev_q;
    assign rx_next     = {rx_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= '0;
            word_q      <= '0;
            is_wr_q     <= 1'b0;
            write_sig_q <= 1'b0;
            rd_req_q    <= 1'b0;
            inc_q       <= 1'b0;
            rd_dly_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cmd_q       <= cmd_d;
            word_q      <= word_d;
            is_wr_q     <= is_wr_d;
            write_sig_q <= write_sig_d;
            rd_req_q    <= rd_req_d;
            inc_q       <= inc_d;
            rd_dly_q    <= rd_dly_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        cmd_d       = cmd_q;
        word_d      = word_q;
        is_wr_d     = is_wr_q;
        write_sig_d = 1'b0;
        rd_req_d    = 1'b0;
        inc_d       = write_sig_q | rd_req_q;
        rd_dly_d    = rd_req_q;

        // Send word is captured two cycles after the request that asked for it.
        if (rd_dly_q) begin
            tx_d = ispi_send_word;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d = CMD;
                end
            end
            CMD, DATA: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sample_edge) begin
                    rx_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (state_q == CMD) begin
                            state_d  = DATA;
                            cmd_d    = rx_next;
                            is_wr_d  = rx_next[DATA_W-1];
                            rd_req_d = ~rx_next[DATA_W-1];
                        end else if (is_wr_q) begin
                            word_d      = rx_next;
                            write_sig_d = 1'b1;
                        end else begin
                            rd_req_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge && (bit_cnt_q != '0)) begin
                    // The shift edge at a word boundary is skipped so the freshly loaded MSB stays on MISO.
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign ospi_out          = ((state_q == DATA) && !is_wr_q) ? tx_q[DATA_W-1] : 1'b0;
    assign ospi_rcv_cmd      = cmd_q;
    assign ospi_rcv_word     = word_q;
    assign ospi_periph_slct  = cmd_q[PSEL_W-1:0];
    assign ospi_write_sig    = write_sig_q;
    assign ospi_inc_wraddr   = inc_q;
    assign ospi_rd_req       = rd_req_q;
    assign ospi_frame_active = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit mode-0 instance plus four 16-bit instances
// covering every CPOL/CPHA combination, checked through strobe scoreboards.
module tb_spi_slave_param;

    localparam int HP = 80;   // SPI half period: 8 system clocks

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Channel 0 is the 8-bit DUT; channels 1..4 are the 16-bit DUTs for modes 0..3
    logic [4:0] sclk_v;
    logic [4:0] ss_v;
    logic [4:0] mosi_v;
    logic [4:0] miso_v;

    logic [7:0] send_word;
    logic [7:0] rcv_cmd;
    logic [7:0] rcv_word;
    logic [4:0] periph;
    logic       wsig;
    logic       inc;
    logic       rd_req;
    logic       factive;

    logic [15:0]      send16;
    logic [3:0][15:0] cmd16;
    logic [3:0][15:0] word16;
    logic [3:0][4:0]  psel16;
    logic [3:0]       wsig16;
    logic [3:0]       inc16;
    logic [3:0]       rdreq16;
    logic [3:0]       fa16;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int inc_cnt  = 0;
    logic prev_strobe = 1'b0;

    int exp_wr_q[$];   // expected rcv_word values of the 8-bit DUT
    int exp16_q[$];    // expected {channel, rcv_word} of the 16-bit DUTs
    int rd_src_q[$];   // peripheral read data handed out on rd_req

    spi_slave_param #(
        .DATA_W(8), .PSEL_W(5), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)
    ) u_dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .ispi_sclk        (sclk_v[0]),
        .ispi_ss_n        (ss_v[0]),
        .ispi_in          (mosi_v[0]),
        .ispi_send_word   (send_word),
        .ospi_out         (miso_v[0]),
        .ospi_rcv_cmd     (rcv_cmd),
        .ospi_rcv_word    (rcv_word),
        .ospi_periph_slct (periph),
        .ospi_write_sig   (wsig),
        .ospi_inc_wraddr  (inc),
        .ospi_rd_req      (rd_req),
        .ospi_frame_active(factive)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        spi_slave_param #(
            .DATA_W(16), .PSEL_W(5), .CPOL(gi / 2), .CPHA(gi % 2), .SYNC_STAGES(2 + gi / 2)
        ) u_dut16 (
            .clk_clk          (clk),
            .reset_reset_n    (rst_n),
            .ispi_sclk        (sclk_v[gi+1]),
            .ispi_ss_n        (ss_v[gi+1]),
            .ispi_in          (mosi_v[gi+1]),
            .ispi_send_word   (send16),
            .ospi_out         (miso_v[gi+1]),
            .ospi_rcv_cmd     (cmd16[gi]),
            .ospi_rcv_word    (word16[gi]),
            .ospi_periph_slct (psel16[gi]),
            .ospi_write_sig   (wsig16[gi]),
            .ospi_inc_wraddr  (inc16[gi]),
            .ospi_rd_req      (rdreq16[gi]),
            .ospi_frame_active(fa16[gi])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor / scoreboard, sampled on the falling clock edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (wsig) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) chk("unexpected_write_sig", 32'(wsig), 32'd0);
                else chk("rcv_word", 32'(rcv_word), exp_wr_q.pop_front());
            end
            if (rd_req) begin
                rd_cnt++;
                send_word = (rd_src_q.size() != 0) ? 8'(rd_src_q.pop_front()) : 8'h00;
            end
            if (prev_strobe || inc) chk("inc_wraddr_follows_strobe", 32'(inc), 32'(prev_strobe));
            if (inc) inc_cnt++;
            prev_strobe = wsig | rd_req;
            for (int m = 0; m < 4; m++) begin
                if (wsig16[m]) begin
                    if (exp16_q.size() == 0) chk("unexpected_write_sig16", 32'(m), 32'hFFFF_FFFF);
                    else chk("rcv_word16", (32'(m) << 16) | 32'(word16[m]), exp16_q.pop_front());
                end
            end
        end
    end

    function automatic int width_of(input int ch);
        return (ch == 0) ? 8 : 16;
    endfunction

    // One SPI word from the master's side; nbits < width gives a truncated word
    task automatic xfer_word(input int ch, input int nbits, input logic [31:0] tx,
                             output logic [31:0] rx);
        logic cpol;
        logic cpha;
        cpol = (ch >= 3);
        cpha = (ch == 2) || (ch == 4);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi_v[ch] = tx[i];
                #HP;
                rx = {rx[30:0], miso_v[ch]};
                sclk_v[ch] = ~cpol;
                #HP;
                sclk_v[ch] = cpol;
            end else begin
                sclk_v[ch] = ~cpol;
                mosi_v[ch] = tx[i];
                #HP;
                rx = {rx[30:0], miso_v[ch]};
                sclk_v[ch] = cpol;
                #HP;
            end
        end
    endtask

    task automatic ss_low(input int ch);
        ss_v[ch] = 1'b0;
        #HP;
    endtask

    task automatic ss_high(input int ch);
        #HP;
        ss_v[ch] = 1'b1;
        #(4 * HP);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rd0, inc0;
        logic [31:0] rx;
        sclk_v    = 5'b11000;
        ss_v      = 5'b11111;
        mosi_v    = 5'b00000;
        send_word = 8'h00;
        send16    = 16'h1234;

        // Reset state
        repeat (4) @(posedge clk);
        #2;
        chk("reset_frame_active", 32'(factive), 32'd0);
        chk("reset_outputs", {miso_v[0], wsig, inc, rd_req, periph, rcv_cmd, rcv_word}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("idle_after_release", {28'd0, fa16}, 32'd0);

        // Write frame: cmd 0x85, data 0x3C, 0xA5
        wr0 = wr_cnt; inc0 = inc_cnt;
        exp_wr_q.push_back(32'h3C);
        exp_wr_q.push_back(32'hA5);
        ss_low(0);
        chk("frame_active_in_frame", 32'(factive), 32'd1);
        xfer_word(0, 8, 32'h85, rx);
        xfer_word(0, 8, 32'h3C, rx);
        xfer_word(0, 8, 32'hA5, rx);
        ss_high(0);
        chk("wr_rcv_cmd", 32'(rcv_cmd), 32'h85);
        chk("wr_periph_slct", 32'(periph), 32'h05);
        chk("wr_write_sig_count", wr_cnt - wr0, 2);
        chk("wr_inc_count", inc_cnt - inc0, 2);
        chk("frame_active_after", 32'(factive), 32'd0);

        // Read frame: cmd 0x03, peripheral supplies 0x5A then 0xC3
        wr0 = wr_cnt; rd0 = rd_cnt; inc0 = inc_cnt;
        rd_src_q.push_back(32'h5A);
        rd_src_q.push_back(32'hC3);
        ss_low(0);
        xfer_word(0, 8, 32'h03, rx);
        xfer_word(0, 8, 32'h00, rx);
        chk("rd_miso_word0", rx, 32'h5A);
        xfer_word(0, 8, 32'h00, rx);
        chk("rd_miso_word1", rx, 32'hC3);
        ss_high(0);
        chk("rd_rcv_cmd", 32'(rcv_cmd), 32'h03);
        chk("rd_periph_slct", 32'(periph), 32'h03);
        chk("rd_req_count", rd_cnt - rd0, 3);
        chk("rd_inc_count", inc_cnt - inc0, 3);
        chk("rd_write_sig_count", wr_cnt - wr0, 0);
        chk("miso_idle_low", 32'(miso_v[0]), 32'd0);

        // Frame aborted inside the command word leaves the command untouched
        ss_low(0);
        xfer_word(0, 4, 32'hF, rx);
        ss_high(0);
        chk("abort_cmd_rcv_cmd", 32'(rcv_cmd), 32'h03);
        chk("abort_cmd_frame_active", 32'(factive), 32'd0);

        // ss_n rises after 5 bits of a data word: no strobe, then a clean frame
        wr0 = wr_cnt;
        ss_low(0);
        xfer_word(0, 8, 32'h82, rx);
        xfer_word(0, 5, 32'h1F, rx);
        ss_high(0);
        chk("abort_data_write_sig", wr_cnt - wr0, 0);
        chk("abort_data_frame_active", 32'(factive), 32'd0);
        exp_wr_q.push_back(32'h77);
        ss_low(0);
        xfer_word(0, 8, 32'h84, rx);
        xfer_word(0, 8, 32'h77, rx);
        ss_high(0);
        chk("after_abort_periph", 32'(periph), 32'h04);
        chk("after_abort_write_sig", wr_cnt - wr0, 1);

        // 300-word write burst
        wr0 = wr_cnt; inc0 = inc_cnt;
        ss_low(0);
        xfer_word(0, 8, 32'h80, rx);
        for (int i = 0; i < 300; i++) begin
            exp_wr_q.push_back((i * 37 + 11) & 32'hFF);
            xfer_word(0, 8, 32'((i * 37 + 11) & 8'hFF), rx);
        end
        ss_high(0);
        chk("burst_write_sig_count", wr_cnt - wr0, 300);
        chk("burst_inc_count", inc_cnt - inc0, 300);

        // 16-bit builds, all four SPI modes: write then read
        for (int m = 0; m < 4; m++) begin
            exp16_q.push_back((m << 16) | 32'hBEEF);
            ss_low(m + 1);
            xfer_word(m + 1, width_of(m + 1), 32'h8001, rx);
            xfer_word(m + 1, width_of(m + 1), 32'hBEEF, rx);
            ss_high(m + 1);
            chk($sformatf("mode%0d_rcv_word", m), 32'(word16[m]), 32'hBEEF);
            ss_low(m + 1);
            xfer_word(m + 1, width_of(m + 1), 32'h0001, rx);
            xfer_word(m + 1, width_of(m + 1), 32'h0000, rx);
            ss_high(m + 1);
            chk($sformatf("mode%0d_miso", m), rx, 32'h1234);
            chk($sformatf("mode%0d_rcv_cmd", m), 32'(cmd16[m]), 32'h0001);
        end

        // Reset asserted mid-command, ss_n kept low through release
        ss_low(0);
        xfer_word(0, 3, 32'h5, rx);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_frame_active", 32'(factive), 32'd0);
        chk("async_reset_rcv_cmd", 32'(rcv_cmd), 32'd0);
        chk("async_reset_rcv_word", 32'(rcv_word), 32'd0);
        chk("async_reset_periph", 32'(periph), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        xfer_word(0, 8, 32'hFF, rx);
        #HP;
        chk("held_ss_ignored_active", 32'(factive), 32'd0);
        chk("held_ss_ignored_cmd", 32'(rcv_cmd), 32'd0);
        ss_high(0);
        exp_wr_q.push_back(32'h11);
        ss_low(0);
        xfer_word(0, 8, 32'h81, rx);
        xfer_word(0, 8, 32'h11, rx);
        ss_high(0);
        chk("post_reset_rcv_cmd", 32'(rcv_cmd), 32'h81);
        chk("post_reset_periph", 32'(periph), 32'h01);

        repeat (10) @(posedge clk);
        chk("exp_wr_q_drained", exp_wr_q.size(), 0);
        chk("exp16_q_drained", exp16_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
